// File: rtl/falling_item_array.sv
`default_nettype none
// ============================================================================
// Module      : falling_item_array
// Description : Owns N_ITEMS independent falling items that share one 16-bit
//               Fibonacci LFSR, a paced spawn scheduler and a speed level.
//               All active items advance once per fall_clk tick. An item is
//               retired when it is caught (collision) or when its next y
//               would reach the floor. Free slots are refilled at a paced rate.
// Ports       : fall_clk  - tick clock, all state changes on the rising edge
//               rst       - asynchronous active-high reset
//               pause     - level, freezes motion, spawning and speed changes
//               collision - per-slot catch request, honoured even when paused
//               speed_up  - one-tick pulse, raises velocity by VEL_STEP
//               pos_x/pos_y - flattened 10-bit positions, slot i at [10i+9:10i]
//               color     - flattened 2-bit colors, slot i at [2i+1:2i]
//               active    - slot holds a live item
//               caught/missed - one-tick retire pulses per slot
//               vel       - current velocity in pixels per tick
// Revision    : 1.0 - initial release
// ============================================================================
module falling_item_array #(
    parameter int          N_ITEMS   = 4,
    parameter int          X_LIMIT   = 640,
    parameter int          FLOOR_Y   = 400,
    parameter int          VEL_INIT  = 5,
    parameter int          VEL_STEP  = 2,
    parameter int          VEL_MAX   = 15,
    parameter int          SPAWN_GAP = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                    fall_clk,
    input  logic                    rst,
    input  logic                    pause,
    input  logic [N_ITEMS-1:0]      collision,
    input  logic                    speed_up,
    output logic [10*N_ITEMS-1:0]   pos_x,
    output logic [10*N_ITEMS-1:0]   pos_y,
    output logic [2*N_ITEMS-1:0]    color,
    output logic [N_ITEMS-1:0]      active,
    output logic [N_ITEMS-1:0]      caught,
    output logic [N_ITEMS-1:0]      missed,
    output logic [3:0]              vel
);

    localparam int c_gap_w = $clog2(SPAWN_GAP + 1);
    localparam int c_idx_w = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;

    localparam logic [0:0]         c_ST_IDLE    = 1'b0;
    localparam logic [0:0]         c_ST_FALLING = 1'b1;

    localparam logic [c_gap_w-1:0] c_gap_reload = c_gap_w'(SPAWN_GAP - 1);
    localparam logic [10:0]        c_floor      = 11'(FLOOR_Y);
    localparam logic [4:0]         c_vel_step   = 5'(VEL_STEP);
    localparam logic [4:0]         c_vel_max    = 5'(VEL_MAX);
    localparam logic [3:0]         c_vel_init   = 4'(VEL_INIT);

    logic [15:0]        r_lfsr;
    logic [1:0]         r_rc;
    logic [c_gap_w-1:0] r_gap;
    logic [0:0]         r_state [N_ITEMS];
    logic [9:0]         r_x     [N_ITEMS];
    logic [9:0]         r_y     [N_ITEMS];
    logic [1:0]         r_col   [N_ITEMS];

    logic               w_fb;
    logic [9:0]         w_spawn_x;
    logic [31:0]        w_rnd_wide;
    logic [1:0]         w_spawn_col;
    logic               w_use_rc;
    logic [1:0]         w_rc_next;
    logic               w_any_idle;
    logic [c_idx_w-1:0] w_idx;
    logic [10:0]        w_y_sum [N_ITEMS];
    logic [4:0]         w_vel_sum;
    logic [3:0]         w_vel_next;

    // Taps 16,14,13,11 (1-based) map to bits 15,13,12,10.
    assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    // A single conditional subtract folds the 10-bit random value into
    // [0, X_LIMIT-1]; this only works because X_LIMIT >= 512.
    assign w_rnd_wide = {22'd0, r_lfsr[9:0]};
    assign w_spawn_x  = (w_rnd_wide >= 32'(X_LIMIT)) ? 10'(w_rnd_wide - 32'(X_LIMIT))
                                                     : r_lfsr[9:0];

    // Color 00 is reserved for idle slots, so fall back to the rotating counter.
    assign w_use_rc    = (r_lfsr[11:10] == 2'b00);
    assign w_spawn_col = w_use_rc ? r_rc : r_lfsr[11:10];
    assign w_rc_next   = (r_rc == 2'd3) ? 2'd1 : r_rc + 2'd1;

    assign w_vel_sum  = {1'b0, vel} + c_vel_step;
    assign w_vel_next = (w_vel_sum > c_vel_max) ? c_vel_max[3:0] : w_vel_sum[3:0];

    // Lowest-index slot that is idle at the start of the tick; slots freed
    // during this tick are still FALLING here, so they wait a tick.
    always_comb begin
        w_any_idle = 1'b0;
        w_idx      = '0;
        for (int i = N_ITEMS - 1; i >= 0; i--) begin
            if (r_state[i] == c_ST_IDLE) begin
                w_any_idle = 1'b1;
                w_idx      = c_idx_w'(i);
            end
        end
    end

    // 11-bit sum so the floor compare cannot wrap.
    always_comb begin
        for (int i = 0; i < N_ITEMS; i++) begin
            w_y_sum[i] = {1'b0, r_y[i]} + {7'd0, vel};
        end
    end

    always_ff @(posedge fall_clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
            r_rc   <= 2'd1;
            r_gap  <= '0;
            vel    <= c_vel_init;
            caught <= '0;
            missed <= '0;
            for (int i = 0; i < N_ITEMS; i++) begin
                r_state[i] <= c_ST_IDLE;
                r_x[i]     <= '0;
                r_y[i]     <= '0;
                r_col[i]   <= '0;
            end
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_fb};
            caught <= '0;
            missed <= '0;

            // Catch outranks the floor and is honoured while paused.
            for (int i = 0; i < N_ITEMS; i++) begin
                if (r_state[i] == c_ST_FALLING) begin
                    if (collision[i]) begin
                        r_state[i] <= c_ST_IDLE;
                        r_y[i]     <= '0;
                        r_col[i]   <= '0;
                        caught[i]  <= 1'b1;
                    end else if (!pause) begin
                        if (w_y_sum[i] >= c_floor) begin
                            r_state[i] <= c_ST_IDLE;
                            r_y[i]     <= '0;
                            r_col[i]   <= '0;
                            missed[i]  <= 1'b1;
                        end else begin
                            r_y[i] <= w_y_sum[i][9:0];
                        end
                    end
                end
            end

            // The spawn target is idle at tick start, so it never collides
            // with the retire writes above.
            if (!pause) begin
                if (r_gap == '0) begin
                    if (w_any_idle) begin
                        r_state[w_idx] <= c_ST_FALLING;
                        r_x[w_idx]     <= w_spawn_x;
                        r_y[w_idx]     <= '0;
                        r_col[w_idx]   <= w_spawn_col;
                        r_gap          <= c_gap_reload;
                        if (w_use_rc) begin
                            r_rc <= w_rc_next;
                        end
                    end
                end else begin
                    r_gap <= r_gap - 1'b1;
                end
                if (speed_up) begin
                    vel <= w_vel_next;
                end
            end
        end
    end

    generate
        for (genvar g = 0; g < N_ITEMS; g++) begin : g_flat
            assign pos_x[10*g +: 10] = r_x[g];
            assign pos_y[10*g +: 10] = r_y[g];
            assign color[2*g +: 2]   = r_col[g];
            assign active[g]         = (r_state[g] == c_ST_FALLING);
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_falling_item_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_falling_item_array
// Description : Self-checking bench for falling_item_array. A reference model
//               is stepped alongside the DUT; spawns are queued as expected
//               records and popped when the DUT shows them. A second instance
//               with SPAWN_GAP=1 covers back-to-back filling and refills.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_falling_item_array;

    logic        fall_clk = 1'b0;
    logic        rst      = 1'b1;
    logic        pause    = 1'b0;
    logic        speed_up = 1'b0;
    logic [3:0]  collision = 4'b0;
    logic [39:0] pos_x, pos_y;
    logic [7:0]  color;
    logic [3:0]  active, caught, missed, vel;

    logic        pause1    = 1'b0;
    logic        speed_up1 = 1'b0;
    logic [3:0]  collision1 = 4'b0;
    logic [39:0] pos_x1, pos_y1;
    logic [7:0]  color1;
    logic [3:0]  active1, caught1, missed1, vel1;

    falling_item_array dut (
        .fall_clk(fall_clk), .rst(rst), .pause(pause), .collision(collision),
        .speed_up(speed_up), .pos_x(pos_x), .pos_y(pos_y), .color(color),
        .active(active), .caught(caught), .missed(missed), .vel(vel)
    );

    falling_item_array #(.SPAWN_GAP(1)) dut1 (
        .fall_clk(fall_clk), .rst(rst), .pause(pause1), .collision(collision1),
        .speed_up(speed_up1), .pos_x(pos_x1), .pos_y(pos_y1), .color(color1),
        .active(active1), .caught(caught1), .missed(missed1), .vel(vel1)
    );

    always #5 fall_clk = ~fall_clk;

    int npass = 0;
    int nfail = 0;
    int nchk  = 0;
    int cyc   = 0;
    int spawns = 0;

    typedef struct {
        int         slot;
        logic [9:0] x;
        logic [1:0] c;
    } spawn_t;
    spawn_t sbq[$];

    // Reference model state
    logic [15:0] m_lfsr;
    logic [1:0]  m_rc;
    int          m_gap;
    int          m_vel;
    logic [3:0]  m_act, m_caught, m_missed;
    logic [9:0]  m_x [4];
    logic [9:0]  m_y [4];
    logic [1:0]  m_c [4];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_lfsr = 16'hACE1;
        m_rc = 2'd1;
        m_gap = 0;
        m_vel = 5;
        m_act = '0;
        m_caught = '0;
        m_missed = '0;
        for (int i = 0; i < 4; i++) begin
            m_x[i] = '0;
            m_y[i] = '0;
            m_c[i] = '0;
        end
    endtask

    task automatic model_edge(input logic p, input logic [3:0] c, input logic su);
        logic [3:0]  idle0;
        logic [10:0] s;
        logic [9:0]  rnd, x;
        logic [1:0]  col;
        logic        fb;
        int          slot;
        idle0 = ~m_act;
        m_caught = '0;
        m_missed = '0;
        for (int i = 0; i < 4; i++) begin
            if (m_act[i]) begin
                if (c[i]) begin
                    m_act[i] = 1'b0; m_y[i] = '0; m_c[i] = '0; m_caught[i] = 1'b1;
                end else if (!p) begin
                    s = {1'b0, m_y[i]} + 11'(m_vel);
                    if (s >= 11'd400) begin
                        m_act[i] = 1'b0; m_y[i] = '0; m_c[i] = '0; m_missed[i] = 1'b1;
                    end else begin
                        m_y[i] = s[9:0];
                    end
                end
            end
        end
        if (!p) begin
            if (m_gap == 0 && idle0 != 4'b0) begin
                slot = -1;
                for (int i = 0; i < 4; i++) if (idle0[i] && slot < 0) slot = i;
                rnd = m_lfsr[9:0];
                x = (rnd >= 10'd640) ? rnd - 10'd640 : rnd;
                col = m_lfsr[11:10];
                if (col == 2'b00) begin
                    col = m_rc;
                    m_rc = (m_rc == 2'd3) ? 2'd1 : m_rc + 2'd1;
                end
                m_act[slot] = 1'b1;
                m_x[slot] = x;
                m_y[slot] = '0;
                m_c[slot] = col;
                sbq.push_back('{slot, x, col});
                m_gap = 15;
            end else if (m_gap > 0) begin
                m_gap--;
            end
            if (su) m_vel = (m_vel + 2 > 15) ? 15 : m_vel + 2;
        end
        fb = m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10];
        m_lfsr = {m_lfsr[14:0], fb};
    endtask

    task automatic compare_all(input string pfx);
        logic [39:0] ex, ey;
        logic [7:0]  ec;
        for (int i = 0; i < 4; i++) begin
            ex[10*i +: 10] = m_x[i];
            ey[10*i +: 10] = m_y[i];
            ec[2*i +: 2]   = m_c[i];
        end
        chk({pfx, "_active"}, active, m_act);
        chk({pfx, "_pos_x"},  pos_x, ex);
        chk({pfx, "_pos_y"},  pos_y, ey);
        chk({pfx, "_color"},  color, ec);
        chk({pfx, "_caught"}, caught, m_caught);
        chk({pfx, "_missed"}, missed, m_missed);
        chk({pfx, "_vel"},    vel, 64'(m_vel));
    endtask

    task automatic tick(input logic p, input logic [3:0] c, input logic su);
        spawn_t e;
        pause = p;
        collision = c;
        speed_up = su;
        model_edge(p, c, su);
        @(posedge fall_clk);
        #1;
        cyc++;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            spawns++;
            chk("spawn_x", pos_x[10*e.slot +: 10], e.x);
            chk("spawn_color", color[2*e.slot +: 2], e.c);
            chk("spawn_x_range", pos_x[10*e.slot +: 10] < 10'd640, 1);
            chk("spawn_color_nz", color[2*e.slot +: 2] != 2'b00, 1);
        end
        compare_all("step");
        if (cyc == 1) begin
            chk("first_spawn_active0", active[0], 1);
            chk("first_spawn_y0", pos_y[9:0], 0);
        end
        if (cyc == 16) chk("slot1_not_yet", active[1], 0);
        if (cyc == 17) chk("slot1_spawn_edge17", active[1], 1);
        if (cyc == 80) chk("slot0_y395", pos_y[9:0], 395);
        if (cyc == 81) begin
            chk("slot0_missed", missed[0], 1);
            chk("slot0_inactive", active[0], 0);
        end
        if (cyc == 82) chk("slot0_missed_pulse_end", missed[0], 0);
        if (cyc >= 1 && cyc <= 4) chk("gap1_fill", active1, 64'((1 << cyc) - 1));
        if (cyc == 83) begin
            chk("gap1_slot2_missed", missed1[2], 1);
            chk("gap1_slot2_freed", active1[2], 0);
        end
        if (cyc == 84) begin
            chk("gap1_slot2_respawn", active1[2], 1);
            chk("gap1_slot2_y0", pos_y1[29:20], 0);
        end
    endtask

    initial begin
        int n;
        int start;
        int ve[6];
        ve = '{7, 9, 11, 13, 15, 15};

        // Reset state
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge fall_clk);
        #1;
        compare_all("reset");
        rst = 1'b0;
        cyc = 0;

        // Free fall of slot 0 to the floor
        repeat (81) tick(1'b0, 4'b0, 1'b0);

        // Catch slot 0 at y=200
        n = 0;
        while (!(m_act[0] && m_y[0] == 10'd200) && n < 200) begin
            tick(1'b0, 4'b0, 1'b0);
            n++;
        end
        chk("reach_y200", pos_y[9:0], 200);
        tick(1'b0, 4'b0001, 1'b0);
        chk("caught0", caught[0], 1);
        chk("caught0_inactive", active[0], 0);
        chk("caught0_y0", pos_y[9:0], 0);
        chk("caught0_no_miss", missed[0], 0);
        tick(1'b0, 4'b0, 1'b0);
        chk("caught0_pulse_end", caught[0], 0);

        // Pause with collision on slot 1 mid-pause
        for (int k = 0; k < 10; k++) begin
            tick(1'b1, (k == 3) ? 4'b0010 : 4'b0000, 1'b0);
            if (k == 3) chk("caught1_paused", caught[1], 1);
        end

        // Speed changes
        tick(1'b1, 4'b0, 1'b1);
        chk("speed_up_paused", vel, 5);
        for (int k = 0; k < 6; k++) begin
            tick(1'b0, 4'b0, 1'b1);
            chk("vel_step", vel, 64'(ve[k]));
        end
        tick(1'b0, 4'b0, 1'b0);

        // Randomised run for at least 200 spawns
        start = spawns;
        n = 0;
        while (spawns - start < 200 && n < 8000) begin
            tick($urandom_range(0, 15) == 0,
                 ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'b0,
                 $urandom_range(0, 31) == 0);
            n++;
        end
        chk("spawn_count_200", (spawns - start) >= 200, 1);

        // Asynchronous reset in the middle of a cycle
        pause = 1'b0;
        collision = 4'b0;
        speed_up = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        sbq.delete();
        compare_all("async_reset");
        @(posedge fall_clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        repeat (3) tick(1'b0, 4'b0, 1'b0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
`default_nettype wire
